reg_file_bist: RTL and testbench
================================

# reg_file_bist

Parametrised built-in self-test controller for the register file. It drives the file's write and read ports through a two-pass march (pattern, then inverted pattern) over every register and reports pass/fail with the first failing address and data. It sits between the board-level harness and the register file, throttled by a divided-clock tick (`step_en`), so a test runs at human speed on the DE1-SoC or at full rate in simulation.

## Interface
Parameters:
- `WIDTH`, 32: register data width in bits (≥ `ADDR_W`).
- `ADDR_W`, 5: register address width in bits.
- `NUM_REGS`, 32: registers tested (≤ 2^`ADDR_W`).
- `SKIP_ZERO`, 0: 1 = exclude address 0 (hardwired-zero register).

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a test; sampled only in IDLE.
- `step_en`  in  1  advance enable / tick; FSM holds when low.
- `wr_en`  out  1  register file write enable.
- `wr_addr`  out  `ADDR_W`  write address.
- `wr_data`  out  `WIDTH`  write data.
- `rd_addr`  out  `ADDR_W`  read address.
- `rd_data`  in  `WIDTH`  combinational read data for `rd_addr`.
- `busy`  out  1  test in progress.
- `done`  out  1  test finished; held until next accepted `start` or reset.
- `pass`  out  1  valid when `done`: 1 = all compares matched.
- `fail_addr`  out  `ADDR_W`  first mismatching address.
- `fail_expected`  out  `WIDTH`  expected data at first mismatch.
- `fail_actual`  out  `WIDTH`  data read at first mismatch.

## Operation
- Address range: `FIRST` = `SKIP_ZERO` ? 1 : 0, `LAST` = `NUM_REGS`-1, `N` = `LAST`-`FIRST`+1. Compare the counter against `LAST` explicitly; never rely on counter overflow, including when `NUM_REGS` = 2^`ADDR_W`.
- Pattern: `seed(a)` = `a` (`ADDR_W` bits) concatenated repeatedly from the LSB upward, truncated to `WIDTH`. Pass 0 uses `seed(a)`; pass 1 uses `~seed(a)`.
- States: IDLE, WRITE, READ, CHECK, DONE.
- IDLE: `start`=1 with `step_en`=1 clears `done`, `pass`, and the fail registers, then goes to WRITE with pass=0 and addr=`FIRST`.
- WRITE: `wr_en` = `step_en` (combinational). `wr_addr` = addr, `wr_data` = pattern. On a step, addr increments; at `LAST` it resets to `FIRST` and the FSM goes to READ.
- READ: `rd_addr` = addr. On a step, `rd_data` is captured into an internal register and the FSM goes to CHECK.
- CHECK: the captured value is compared with the pattern.
  - Mismatch: load `fail_addr`/`fail_expected`/`fail_actual`, set `pass`=0, go to DONE.
  - Match, not at `LAST`: increment addr, go to READ.
  - Match at `LAST`, pass 0: set pass=1, addr=`FIRST`, go to WRITE.
  - Match at `LAST`, pass 1: set `pass`=1, go to DONE.
- DONE: `done`=1, `busy`=0. `start`=1 with `step_en`=1 behaves as in IDLE and restarts the test.
- `busy` = 1 in WRITE/READ/CHECK. `start` is ignored while busy.
- `wr_en` is never 1 outside WRITE. `rd_addr` holds its last value outside READ.

## Timing
- Reset (`rst`=0, asynchronous): FSM goes to IDLE. All outputs 0: `wr_en`, `wr_addr`, `wr_data`, `rd_addr`, `busy`, `done`, `pass`, and the fail fields. `wr_en` drops without waiting for a clock edge.
- Reset mid-test aborts with no partial result. After release, the FSM waits for `start`.
- With `step_en` held high, counting from the edge that samples `start` (edge 0):
  - Writes commit on edges 1..N.
  - Pass 0 ends at edge 3N.
  - `done`=1 and `pass`=1 are visible after edge 6N.
- A failure reaches DONE on the CHECK edge of the failing address.
- `step_en`=0 freezes state, addr, and pass, and forces `wr_en`=0. Latency scales with the step period.

## Test plan
- Ideal register-file model, defaults, `step_en`=1, pulse `start` → `busy` next cycle; `done`=1, `pass`=1 after exactly 192 cycles; 64 writes observed.
- Model with reg 7 bit 3 stuck at 0 → pass 0 clean; `done`, `pass`=0, `fail_addr`=7, `fail_expected`=0x318C6318, `fail_actual`=0x318C6310.
- Model with reg 0 hardwired zero, `SKIP_ZERO`=0 → fail at pass 1: `fail_addr`=0, `fail_expected`=0xFFFFFFFF, `fail_actual`=0. Same model with `SKIP_ZERO`=1 → `pass`=1 after 186 cycles; no access to address 0.
- `step_en` high one cycle in four → identical write/read sequence; `done` after 768 cycles; `wr_en` never high on a cycle where `step_en`=0.
- `rst` low for 1 cycle mid-pass-1 READ → all outputs 0 immediately; `start` ignored until release; a fresh run then passes in 192 cycles.
- `start` pulsed while busy → no effect. `start` in DONE → fail fields cleared and test reruns. `ADDR_W`=3, `NUM_REGS`=8 → counter wraps at 7 with no overflow; `pass` after 48 cycles.

Source files
------------

// File: rtl/reg_file_bist.sv
// March-style self-test for a register file: write the pattern to every register, read it
// back, then repeat with the inverted pattern. Reports the first mismatch.
module reg_file_bist #(
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_REGS  = 32,
  parameter int SKIP_ZERO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [WIDTH-1:0]  fail_expected,
  output logic [WIDTH-1:0]  fail_actual
);

  // state    | meaning
  // S_IDLE   | waiting for start after reset
  // S_WRITE  | writing the current pattern, one register per step
  // S_READ   | capturing rd_data for the current address
  // S_CHECK  | comparing the captured word against the pattern
  // S_DONE   | result held; start reruns the test
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_CHECK, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] FIRST = (SKIP_ZERO != 0) ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic              phase;
  logic [WIDTH-1:0]  capt;
  logic [WIDTH-1:0]  pattern;

  function automatic logic [WIDTH-1:0] seed(input logic [ADDR_W-1:0] a);
    logic [WIDTH-1:0] s;
    s = '0;
    for (int i = 0; i < WIDTH; i++) s[i] = a[i % ADDR_W];
    return s;
  endfunction

  assign pattern = phase ? ~seed(addr) : seed(addr);
  assign wr_en   = (state == S_WRITE) && step_en;
  assign wr_addr = addr;
  assign wr_data = pattern;

  // LAST is compared explicitly so a full 2^ADDR_W range never depends on wrap-around.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      addr          <= '0;
      phase         <= 1'b0;
      capt          <= '0;
      rd_addr       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail_addr     <= '0;
      fail_expected <= '0;
      fail_actual   <= '0;
    end else if (step_en) begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            done          <= 1'b0;
            pass          <= 1'b0;
            fail_addr     <= '0;
            fail_expected <= '0;
            fail_actual   <= '0;
            phase         <= 1'b0;
            addr          <= FIRST;
            busy          <= 1'b1;
            state         <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (addr == LAST) begin
            addr    <= FIRST;
            rd_addr <= FIRST;
            state   <= S_READ;
          end else begin
            addr <= addr + ADDR_W'(1);
          end
        end
        S_READ: begin
          capt  <= rd_data;
          state <= S_CHECK;
        end
        S_CHECK: begin
          if (capt != pattern) begin
            fail_addr     <= addr;
            fail_expected <= pattern;
            fail_actual   <= capt;
            pass          <= 1'b0;
            done          <= 1'b1;
            busy          <= 1'b0;
            state         <= S_DONE;
          end else if (addr != LAST) begin
            addr    <= addr + ADDR_W'(1);
            rd_addr <= addr + ADDR_W'(1);
            state   <= S_READ;
          end else if (!phase) begin
            phase <= 1'b1;
            addr  <= FIRST;
            state <= S_WRITE;
          end else begin
            pass  <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_bist.sv
// Directed bench for reg_file_bist: three instances (default, SKIP_ZERO, 3-bit address)
// each backed by a behavioural register file with optional injected faults.
module tb_reg_file_bist;

  logic clk, rst, step_en;
  logic start_a, start_b, start_c;

  logic        wr_en_a, busy_a, done_a, pass_a;
  logic [4:0]  wr_addr_a, rd_addr_a, fail_addr_a;
  logic [31:0] wr_data_a, rd_data_a, fail_exp_a, fail_act_a;

  logic        wr_en_b, busy_b, done_b, pass_b;
  logic [4:0]  wr_addr_b, rd_addr_b, fail_addr_b;
  logic [31:0] wr_data_b, rd_data_b, fail_exp_b, fail_act_b;

  logic        wr_en_c, busy_c, done_c, pass_c;
  logic [2:0]  wr_addr_c, rd_addr_c, fail_addr_c;
  logic [7:0]  wr_data_c, rd_data_c, fail_exp_c, fail_act_c;

  logic [31:0] mem_a [32];
  logic [31:0] mem_b [32];
  logic [7:0]  mem_c [8];
  int fault_a, fault_b;

  int total, passed, failed;
  int writes_a, writes_b, writes_c, zero_wr_b, wr_bad, wseq_err_a, widx_a;

  reg_file_bist u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .step_en(step_en),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .rd_addr(rd_addr_a),
    .rd_data(rd_data_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_addr(fail_addr_a), .fail_expected(fail_exp_a), .fail_actual(fail_act_a)
  );

  reg_file_bist #(.SKIP_ZERO(1)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .step_en(step_en),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .rd_addr(rd_addr_b),
    .rd_data(rd_data_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_addr(fail_addr_b), .fail_expected(fail_exp_b), .fail_actual(fail_act_b)
  );

  reg_file_bist #(.WIDTH(8), .ADDR_W(3), .NUM_REGS(8)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_c), .step_en(step_en),
    .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c), .rd_addr(rd_addr_c),
    .rd_data(rd_data_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .fail_addr(fail_addr_c), .fail_expected(fail_exp_c), .fail_actual(fail_act_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // fault 1: reg 7 bit 3 stuck at 0; fault 2: reg 0 hardwired to zero
  always_comb begin
    rd_data_a = mem_a[rd_addr_a];
    if (fault_a == 1 && rd_addr_a == 5'd7) rd_data_a[3] = 1'b0;
    if (fault_a == 2 && rd_addr_a == 5'd0) rd_data_a = '0;
    rd_data_b = mem_b[rd_addr_b];
    if (fault_b == 2 && rd_addr_b == 5'd0) rd_data_b = '0;
    rd_data_c = mem_c[rd_addr_c];
  end

  function automatic logic [31:0] tb_seed5(input logic [4:0] a);
    logic [31:0] s;
    for (int i = 0; i < 32; i++) s[i] = a[i % 5];
    return s;
  endfunction

  function automatic logic [31:0] exp_wr_a(input int idx);
    logic [31:0] d;
    d = tb_seed5(5'(idx % 32));
    return (idx >= 32) ? ~d : d;
  endfunction

  // Sampled mid-low-phase: inputs settle at the falling edge, the rising edge is 2 units away.
  always @(negedge clk) begin
    #3;
    if (wr_en_a) mem_a[wr_addr_a] <= wr_data_a;
    if (wr_en_b) mem_b[wr_addr_b] <= wr_data_b;
    if (wr_en_c) mem_c[wr_addr_c] <= wr_data_c;
    if (wr_en_a) writes_a <= writes_a + 1;
    if (wr_en_b) writes_b <= writes_b + 1;
    if (wr_en_c) writes_c <= writes_c + 1;
    if (wr_en_b && wr_addr_b == 5'd0) zero_wr_b <= zero_wr_b + 1;
    if ((wr_en_a || wr_en_b || wr_en_c) && !step_en) wr_bad <= wr_bad + 1;
    if (start_a && step_en && !busy_a) widx_a <= 0;
    else if (wr_en_a) begin
      if (wr_addr_a !== 5'(widx_a % 32) || wr_data_a !== exp_wr_a(widx_a))
        wseq_err_a <= wseq_err_a + 1;
      widx_a <= widx_a + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic drive_start(input int sel, input logic v);
    case (sel)
      0:       start_a = v;
      1:       start_b = v;
      default: start_c = v;
    endcase
  endtask

  function automatic logic sel_busy(input int sel);
    case (sel)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic sel_done(input int sel);
    case (sel)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  // Called at a falling edge; edge 0 is the next rising edge, cycles counts edges after it.
  task automatic run_test(input int sel, input int step_div, input int poke_at, input int budget,
                          output int cycles, output logic timed_out, output logic busy0,
                          output logic done0, output logic [31:0] fexp0);
    timed_out = 1'b1;
    cycles    = 0;
    step_en   = 1'b1;
    drive_start(sel, 1'b1);
    @(negedge clk);
    drive_start(sel, 1'b0);
    busy0 = sel_busy(sel);
    done0 = sel_done(sel);
    fexp0 = fail_exp_a;
    for (int k = 1; k <= budget; k++) begin
      step_en = ((k % step_div) == 0);
      drive_start(sel, k == poke_at);
      @(negedge clk);
      cycles = k;
      if (sel_done(sel)) begin
        timed_out = 1'b0;
        break;
      end
    end
    drive_start(sel, 1'b0);
    step_en = 1'b1;
  endtask

  int          cyc, w0, e0, z0, b0;
  logic        tmo, busy0, done0;
  logic [31:0] fexp0;

  initial begin
    total = 0; passed = 0; failed = 0;
    fault_a = 0; fault_b = 0;
    rst = 1'b0; step_en = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_wr_en", 64'(wr_en_a), 64'(0));
    check("reset_ctrl", 64'({wr_addr_a, rd_addr_a, busy_a, done_a, pass_a, fail_addr_a}), 64'(0));
    check("reset_data", 64'({wr_data_a, fail_exp_a}), 64'(0));
    check("reset_fail_actual", 64'(fail_act_a), 64'(0));
    rst = 1'b1;
    @(negedge clk);

    // ideal file, full rate
    w0 = writes_a; e0 = wseq_err_a; b0 = wr_bad;
    run_test(0, 1, 0, 400, cyc, tmo, busy0, done0, fexp0);
    check("ideal_timeout", 64'(tmo), 64'(0));
    check("ideal_busy_next", 64'(busy0), 64'(1));
    check("ideal_cycles", 64'(cyc), 64'(192));
    check("ideal_done_pass", 64'({done_a, pass_a, busy_a}), 64'(3'b110));
    check("ideal_writes", 64'(writes_a - w0), 64'(64));
    check("ideal_wr_seq", 64'(wseq_err_a - e0), 64'(0));

    // reg 7 bit 3 stuck at 0: clean in pass 0, fails on pass-1 CHECK of address 7
    fault_a = 1;
    run_test(0, 1, 0, 400, cyc, tmo, busy0, done0, fexp0);
    check("stuck_cycles", 64'(cyc), 64'(144));
    check("stuck_done_pass", 64'({done_a, pass_a}), 64'(2'b10));
    check("stuck_fail_addr", 64'(fail_addr_a), 64'(7));
    check("stuck_fail_expected", 64'(fail_exp_a), 64'(32'h318C6318));
    check("stuck_fail_actual", 64'(fail_act_a), 64'(32'h318C6310));

    // restart from DONE with the fault removed: fields cleared on the start edge
    fault_a = 0;
    run_test(0, 1, 0, 400, cyc, tmo, busy0, done0, fexp0);
    check("rerun_done_cleared", 64'(done0), 64'(0));
    check("rerun_fexp_cleared", 64'(fexp0), 64'(0));
    check("rerun_cycles", 64'(cyc), 64'(192));
    check("rerun_result", 64'({pass_a, fail_addr_a, fail_act_a}), 64'({1'b1, 5'd0, 32'd0}));

    // hardwired-zero reg 0 without SKIP_ZERO: fails on the first pass-1 CHECK
    fault_a = 2;
    run_test(0, 1, 0, 400, cyc, tmo, busy0, done0, fexp0);
    check("zero_cycles", 64'(cyc), 64'(130));
    check("zero_fail", 64'({pass_a, fail_addr_a}), 64'(0));
    check("zero_fail_expected", 64'(fail_exp_a), 64'(32'hFFFFFFFF));
    check("zero_fail_actual", 64'(fail_act_a), 64'(0));
    fault_a = 0;

    // one step in four
    w0 = writes_a; e0 = wseq_err_a; b0 = wr_bad;
    run_test(0, 4, 0, 1000, cyc, tmo, busy0, done0, fexp0);
    check("slow_timeout", 64'(tmo), 64'(0));
    check("slow_cycles", 64'(cyc), 64'(768));
    check("slow_pass", 64'(pass_a), 64'(1));
    check("slow_writes", 64'(writes_a - w0), 64'(64));
    check("slow_wr_seq", 64'(wseq_err_a - e0), 64'(0));
    check("slow_wr_en_gated", 64'(wr_bad - b0), 64'(0));

    // start pulsed while busy is ignored
    w0 = writes_a;
    run_test(0, 1, 50, 400, cyc, tmo, busy0, done0, fexp0);
    check("poke_cycles", 64'(cyc), 64'(192));
    check("poke_pass", 64'(pass_a), 64'(1));
    check("poke_writes", 64'(writes_a - w0), 64'(64));

    // reset pulse during pass-1 READ
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (140) @(negedge clk);
    check("mid_busy", 64'(busy_a), 64'(1));
    rst = 1'b0;
    #1;
    check("mid_rst_wr_en", 64'(wr_en_a), 64'(0));
    check("mid_rst_ctrl", 64'({wr_addr_a, rd_addr_a, busy_a, done_a, pass_a, fail_addr_a}), 64'(0));
    check("mid_rst_data", 64'({wr_data_a, fail_act_a}), 64'(0));
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_start_ignored", 64'({busy_a, done_a}), 64'(0));
    run_test(0, 1, 0, 400, cyc, tmo, busy0, done0, fexp0);
    check("mid_rst_rerun_cycles", 64'(cyc), 64'(192));
    check("mid_rst_rerun_pass", 64'(pass_a), 64'(1));

    // SKIP_ZERO instance over the hardwired-zero model
    fault_b = 2;
    w0 = writes_b; z0 = zero_wr_b;
    run_test(1, 1, 0, 400, cyc, tmo, busy0, done0, fexp0);
    check("skip_cycles", 64'(cyc), 64'(186));
    check("skip_pass", 64'(pass_b), 64'(1));
    check("skip_writes", 64'(writes_b - w0), 64'(62));
    check("skip_zero_writes", 64'(zero_wr_b - z0), 64'(0));
    check("skip_last_rd_addr", 64'(rd_addr_b), 64'(31));

    // full 3-bit address space: counter must stop at 7 without wrapping
    w0 = writes_c;
    run_test(2, 1, 0, 200, cyc, tmo, busy0, done0, fexp0);
    check("small_cycles", 64'(cyc), 64'(48));
    check("small_pass", 64'(pass_c), 64'(1));
    check("small_writes", 64'(writes_c - w0), 64'(16));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
